// File: rtl/count_disp_ctrl.sv
// count_disp_ctrl
//   Sits behind a 4-bit up/down counter. Samples the counter value and its
//   direction select every clock and extends the count to 8 bits by tracking
//   wraps in a 4-bit wrap count ({wrap_cnt, count}). It flags illegal steps
//   (sticky until reset) and direction reversals, and drives a two-digit
//   time-multiplexed hex 7-segment display: digit 0 = count, digit 1 = wrap
//   count.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   cnt_in     in   [3:0] counter value from upstream
//   dir_in     in   direction fed to the counter (1 = up, 0 = down)
//   seg_out    out  [6:0] segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   dig_en     out  [1:0] digit enables, bit0 = count, bit1 = wrap count
//   wrap_pulse out  one-cycle pulse on an up- or down-wrap
//   wrap_cnt   out  [3:0] wrap count (upper nibble of the 8-bit value)
//   dir_change out  one-cycle pulse when dir_in toggles
//   step_err   out  sticky illegal-step flag
module count_disp_ctrl #(
  parameter int REFRESH_DIV    = 1024,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cnt_in,
  input  logic       dir_in,
  output logic [6:0] seg_out,
  output logic [1:0] dig_en,
  output logic       wrap_pulse,
  output logic [3:0] wrap_cnt,
  output logic       dir_change,
  output logic       step_err
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0] DIG_OFF = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [3:0]    cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic          valid_q, valid_d;
  logic [3:0]    wrap_cnt_q, wrap_cnt_d;
  logic          wrap_pulse_q, wrap_pulse_d;
  logic          dir_change_q, dir_change_d;
  logic          step_err_q, step_err_d;
  logic [RW-1:0] refresh_q, refresh_d;
  logic          dig_sel_q, dig_sel_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    dig_en_q, dig_en_d;

  logic [3:0] cnt_inc, cnt_dec, digit;
  logic       up_wrap, down_wrap, legal;
  logic [6:0] seg_hi;
  logic [1:0] dig_hi;

  always_comb begin
    cnt_d        = cnt_in;
    dir_d        = dir_in;
    valid_d      = 1'b1;
    wrap_cnt_d   = wrap_cnt_q;
    wrap_pulse_d = 1'b0;
    dir_change_d = 1'b0;
    step_err_d   = step_err_q;

    cnt_inc   = cnt_q + 4'd1;
    cnt_dec   = cnt_q - 4'd1;
    // Wraps are classified purely by value pair; dir_in plays no part.
    up_wrap   = (cnt_q == 4'hF) && (cnt_in == 4'h0);
    down_wrap = (cnt_q == 4'h0) && (cnt_in == 4'hF);
    legal     = (cnt_in == cnt_q) || (cnt_in == cnt_inc) || (cnt_in == cnt_dec);

    // The first sample after reset has no valid predecessor to compare with.
    if (valid_q) begin
      if (up_wrap) begin
        wrap_pulse_d = 1'b1;
        wrap_cnt_d   = wrap_cnt_q + 4'd1;
      end else if (down_wrap) begin
        wrap_pulse_d = 1'b1;
        wrap_cnt_d   = wrap_cnt_q - 4'd1;
      end
      if (!legal) step_err_d = 1'b1;
      dir_change_d = (dir_in != dir_q);
    end

    // Refresh divider: each digit stays lit for REFRESH_DIV cycles.
    if (refresh_q == REF_LAST) begin
      refresh_d = '0;
      dig_sel_d = ~dig_sel_q;
    end else begin
      refresh_d = refresh_q + RW'(1);
      dig_sel_d = dig_sel_q;
    end

    digit    = dig_sel_q ? wrap_cnt_q : cnt_q;
    seg_hi   = hex7(digit);
    dig_hi   = dig_sel_q ? 2'b10 : 2'b01;
    seg_d    = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    dig_en_d = SEG_ACTIVE_LOW ? ~dig_hi : dig_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      valid_q      <= 1'b0;
      wrap_cnt_q   <= '0;
      wrap_pulse_q <= 1'b0;
      dir_change_q <= 1'b0;
      step_err_q   <= 1'b0;
      refresh_q    <= '0;
      dig_sel_q    <= 1'b0;
      seg_q        <= SEG_OFF;
      dig_en_q     <= DIG_OFF;
    end else begin
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      valid_q      <= valid_d;
      wrap_cnt_q   <= wrap_cnt_d;
      wrap_pulse_q <= wrap_pulse_d;
      dir_change_q <= dir_change_d;
      step_err_q   <= step_err_d;
      refresh_q    <= refresh_d;
      dig_sel_q    <= dig_sel_d;
      seg_q        <= seg_d;
      dig_en_q     <= dig_en_d;
    end
  end

  assign seg_out    = seg_q;
  assign dig_en     = dig_en_q;
  assign wrap_pulse = wrap_pulse_q;
  assign wrap_cnt   = wrap_cnt_q;
  assign dir_change = dir_change_q;
  assign step_err   = step_err_q;

endmodule

// File: tb/tb_count_disp_ctrl.sv
// Directed bench for count_disp_ctrl (REFRESH_DIV=4, active-low display).
module tb_count_disp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cnt_in;
  logic       dir_in;
  logic [6:0] seg_out;
  logic [1:0] dig_en;
  logic       wrap_pulse;
  logic [3:0] wrap_cnt;
  logic       dir_change;
  logic       step_err;

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;   // edges since reset released
  int n_wrap  = 0;
  int n_dchg  = 0;
  int n_bad_dig = 0;

  count_disp_ctrl #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .dir_in(dir_in),
    .seg_out(seg_out), .dig_en(dig_en), .wrap_pulse(wrap_pulse),
    .wrap_cnt(wrap_cnt), .dir_change(dir_change), .step_err(step_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present inputs, take one edge, sample 1 time unit later.
  task automatic step(input logic [3:0] c, input logic d);
    logic r;
    cnt_in = c;
    dir_in = d;
    r = rst;
    @(posedge clk);
    #1;
    if (r) k = 0;
    else begin
      k++;
      n_wrap += int'(wrap_pulse);
      n_dchg += int'(dir_change);
      if (!(dig_en == 2'b01 || dig_en == 2'b10)) n_bad_dig++;
    end
  endtask

  task automatic ramp_up(input int lo, input int hi, input logic d);
    for (int v = lo; v <= hi; v++) step(4'(v), d);
  endtask

  task automatic ramp_dn(input int hi, input int lo, input logic d);
    for (int v = hi; v >= lo; v--) step(4'(v), d);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_seg"},  32'(seg_out), 32'h7F);
    chk({tag, "_dig"},  32'(dig_en), 32'h3);
    chk({tag, "_wp"},   32'(wrap_pulse), 32'h0);
    chk({tag, "_wc"},   32'(wrap_cnt), 32'h0);
    chk({tag, "_dc"},   32'(dir_change), 32'h0);
    chk({tag, "_serr"}, 32'(step_err), 32'h0);
  endtask

  initial begin
    logic [1:0] exp_dig;
    logic [6:0] exp_seg;
    int sel;
    rst = 1'b1; cnt_in = 4'h0; dir_in = 1'b0;
    step(4'h0, 1'b0);
    step(4'h0, 1'b0);
    chk_reset_outs("rst");

    // 1: two up passes plus a final 0 -> two wraps
    rst = 1'b0;
    n_wrap = 0; n_dchg = 0;
    ramp_up(0, 15, 1'b1);
    ramp_up(0, 15, 1'b1);
    step(4'h0, 1'b1);
    chk("up_npulse", 32'(n_wrap), 32'd2);
    chk("up_wc",     32'(wrap_cnt), 32'd2);
    chk("up_serr",   32'(step_err), 32'd0);
    chk("up_ndchg",  32'(n_dchg), 32'd0);

    // 2: walk up to 3, reverse, down-wrap three times
    ramp_up(1, 3, 1'b1);
    step(4'h2, 1'b0);
    chk("dn_dchg", 32'(dir_change), 32'd1);
    step(4'h1, 1'b0);
    chk("dn_dchg_off", 32'(dir_change), 32'd0);
    step(4'h0, 1'b0);
    step(4'hF, 1'b0);
    chk("dn1_wp", 32'(wrap_pulse), 32'd1);
    chk("dn1_wc", 32'(wrap_cnt), 32'd1);
    ramp_dn(14, 0, 1'b0);
    chk("dn_wp_off", 32'(wrap_pulse), 32'd0);
    step(4'hF, 1'b0);
    chk("dn2_wc", 32'(wrap_cnt), 32'd0);
    ramp_dn(14, 0, 1'b0);
    step(4'hF, 1'b0);
    chk("dn3_wp",   32'(wrap_pulse), 32'd1);
    chk("dn3_wc",   32'(wrap_cnt), 32'd15);
    chk("dn3_serr", 32'(step_err), 32'd0);

    // 3: wrap and direction change on the same edge
    step(4'h0, 1'b1);
    chk("dw_wp", 32'(wrap_pulse), 32'd1);
    chk("dw_dc", 32'(dir_change), 32'd1);
    chk("dw_wc", 32'(wrap_cnt), 32'd0);
    step(4'h0, 1'b1);
    chk("dw_wp_off", 32'(wrap_pulse), 32'd0);
    chk("dw_dc_off", 32'(dir_change), 32'd0);

    // 4: illegal step 5 -> 9, sticky
    ramp_up(1, 5, 1'b1);
    chk("ill_pre", 32'(step_err), 32'd0);
    step(4'h9, 1'b1);
    chk("ill_serr", 32'(step_err), 32'd1);
    chk("ill_wc",   32'(wrap_cnt), 32'd0);
    step(4'hA, 1'b1);
    step(4'hB, 1'b1);
    chk("ill_sticky", 32'(step_err), 32'd1);

    // 5: display mux, cnt=10, wrap_cnt=3
    rst = 1'b1;
    step(4'h0, 1'b1);
    chk("rst2_serr", 32'(step_err), 32'd0);
    rst = 1'b0;
    for (int p = 0; p < 3; p++) begin
      ramp_up(1, 15, 1'b1);
      step(4'h0, 1'b1);
    end
    chk("mux_wc", 32'(wrap_cnt), 32'd3);
    ramp_up(1, 10, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(4'hA, 1'b1);
      sel = ((k - 1) / 4) % 2;
      exp_dig = (sel == 1) ? 2'b01 : 2'b10;
      exp_seg = (sel == 1) ? ~7'h4F : ~7'h77;
      chk($sformatf("mux_dig%0d", i), 32'(dig_en), 32'(exp_dig));
      chk($sformatf("mux_seg%0d", i), 32'(seg_out), 32'(exp_seg));
    end
    chk("mux_onehot", 32'(n_bad_dig), 32'd0);

    // 6: build wrap_cnt=7, step_err=1, cnt at 15, then reset
    ramp_up(11, 15, 1'b1);
    step(4'h0, 1'b1);
    for (int p = 0; p < 3; p++) begin
      ramp_up(1, 15, 1'b1);
      step(4'h0, 1'b1);
    end
    step(4'h8, 1'b1);
    ramp_up(9, 15, 1'b1);
    chk("pre_wc",   32'(wrap_cnt), 32'd7);
    chk("pre_serr", 32'(step_err), 32'd1);
    rst = 1'b1;
    step(4'hF, 1'b1);
    chk_reset_outs("mrst");
    rst = 1'b0;
    step(4'h0, 1'b0);
    chk("post_wp",   32'(wrap_pulse), 32'd0);
    chk("post_serr", 32'(step_err), 32'd0);
    chk("post_wc",   32'(wrap_cnt), 32'd0);
    chk("post_dig",  32'(dig_en), 32'h2);
    chk("post_seg",  32'(seg_out), 32'h40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
